sync_fifo: RTL

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/fifo_pkg.sv | 13 +
 rtl/ram_sdp_sync.sv | 32 +++
 rtl/sync_fifo.sv | 116 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO family.
// Mode selectors and the occupancy-counter width rule live here so every variant agrees.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit more than the address.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/ram_sdp_sync.sv
// Simple dual-port RAM, single clock, registered read; maps onto block RAM.
// Only the read register is cleared by rst, which block RAM output registers support.
module ram_sdp_sync
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset branch; a reset would stop block RAM inference and
  // buys nothing, because the FIFO never reads a word it has not written first.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags, sticky error flags and an optional
// first-word-fall-through front end built from a two-stage prefetch (RAM read register + output register).
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int FWFT       = FWFT_OFF,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  input  logic                                wr_en,
  output logic                                full,
  output logic                                almost_full,
  input  logic                                rd_en,
  output logic [DATA_WIDTH-1:0]               rd_data,
  output logic                                rd_valid,
  output logic                                empty,
  output logic                                almost_empty,
  output logic [count_width(ADDR_WIDTH)-1:0]  count,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int DEPTH     = 2**ADDR_WIDTH;
  localparam int CW        = count_width(ADDR_WIDTH);
  localparam bit FWFT_MODE = (FWFT == FWFT_ON);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (ADDR_WIDTH < 2 || AE_LEVEL <= 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL >= DEPTH ||
      (FWFT != FWFT_OFF && FWFT != FWFT_ON)) begin : g_bad_params
    $fatal(1, "sync_fifo: illegal parameter combination");
  end

  logic [CW-1:0]         wr_ptr, rd_ptr, count_next;
  logic                  wr_acc, rd_acc, ram_re, mem_has;
  logic                  mid_valid, out_valid, out_load, mid_next, out_next;
  logic [DATA_WIDTH-1:0] ram_rdata, out_q;

  // NOTE: every signal gets a default at the top of the block so that no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_acc   = wr_en && !full;
    rd_acc   = rd_en && !empty;
    mem_has  = (wr_ptr != rd_ptr);
    ram_re   = rd_acc;
    out_load = 1'b0;
    mid_next = 1'b0;
    out_next = 1'b0;
    if (FWFT_MODE) begin
      // Words flow RAM -> read register (mid) -> output register; each stage refills as soon as it drains.
      out_load = mid_valid && (!out_valid || rd_acc);
      ram_re   = mem_has && (!mid_valid || out_load);
      mid_next = ram_re || (mid_valid && !out_load);
      out_next = out_load || (out_valid && !rd_acc);
    end
    count_next = count + CW'(wr_acc) - CW'(rd_acc);
  end

  ram_sdp_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      mid_valid    <= 1'b0;
      out_valid    <= 1'b0;
      out_q        <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (ram_re) rd_ptr <= rd_ptr + CW'(1);
      count        <= count_next;
      full         <= (count_next == DEPTH_C);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
      empty        <= FWFT_MODE ? !out_next : (count_next == '0);
      rd_valid     <= FWFT_MODE ? out_next : rd_acc;
      overflow     <= overflow | (wr_en & full);
      underflow    <= underflow | (rd_en & empty);
      mid_valid    <= mid_next;
      out_valid    <= out_next;
      if (out_load) out_q <= ram_rdata;
    end
  end

  assign rd_data = FWFT_MODE ? out_q : ram_rdata;

endmodule
